// File: rtl/instruction_memory_loadable.sv
// Run-time loadable instruction memory: a boot loader streams a program in over
// valid/ready while the CPU is held, then the CPU fetches by byte address.
module instruction_memory_loadable #(
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    REG_READ      = 0,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_INSTR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  AddrFault,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     words_q, words_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    run;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    fetch_fault;
  logic [DATA_WIDTH-1:0]   fetch_word;

  // A zero or oversized request means "fill the whole memory".
  function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] n);
    if (n == '0 || n > DEPTH_W) return DEPTH_W;
    return n;
  endfunction

  assign accept = (state_q == LOAD) && load_valid;
  assign run    = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    len_d   = len_q;
    case (state_q)
      IDLE, RUN: begin
        if (load_start) begin
          state_d = LOAD;
          words_d = '0;
          len_d   = clamp_len(load_len);
        end
      end
      LOAD: begin
        if (accept) begin
          words_d = words_q + 1'b1;
          if (words_d == len_q) state_d = DONE;
        end
      end
      DONE:    state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      words_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      len_q   <= len_d;
    end
  end

  // Program storage is not reset; words_loaded masks anything stale.
  always_ff @(posedge clk) begin
    if (accept) mem[words_q[ADDR_WIDTH-1:0]] <= load_data;
  end

  assign load_ready   = (state_q == LOAD);
  assign load_done    = (state_q == DONE);
  assign cpu_hold     = !run;
  assign words_loaded = words_q;

  assign idx         = Address[ADDR_WIDTH+1:2];
  assign fetch_fault = (|Address[1:0]) || (|Address[31:ADDR_WIDTH+2]) ||
                       ({1'b0, idx} >= words_q);
  assign fetch_word  = fetch_fault ? DEFAULT_INSTR : mem[idx];

  generate
    if (REG_READ == 0) begin : g_comb_read
      assign Instruction = run ? fetch_word : DEFAULT_INSTR;
      assign AddrFault   = run && fetch_fault;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] instr_q;
      logic                  fault_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          instr_q <= DEFAULT_INSTR;
          fault_q <= 1'b0;
        end else begin
          instr_q <= run ? fetch_word : DEFAULT_INSTR;
          fault_q <= run && fetch_fault;
        end
      end

      assign Instruction = instr_q;
      assign AddrFault   = fault_q;
    end
  endgenerate

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Bench for instruction_memory_loadable: combinational and registered-read
// instances share stimulus and are compared each cycle against a program-queue model.
module tb_instruction_memory_loadable;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic        load_start;
  logic [8:0]  load_len;
  logic        load_valid;
  logic [31:0] load_data;

  logic [31:0] d0_instr, d1_instr;
  logic        d0_fault, d1_fault;
  logic        d0_ready, d1_ready, d0_done, d1_done, d0_hold, d1_hold;
  logic [8:0]  d0_words, d1_words;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_memory_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .REG_READ(0),
                                .DEFAULT_INSTR(32'h0)) dut0 (
    .clk(clk), .reset(reset), .Address(Address), .Instruction(d0_instr),
    .AddrFault(d0_fault), .load_start(load_start), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(d0_ready),
    .load_done(d0_done), .cpu_hold(d0_hold), .words_loaded(d0_words));

  instruction_memory_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .REG_READ(1),
                                .DEFAULT_INSTR(32'h0)) dut1 (
    .clk(clk), .reset(reset), .Address(Address), .Instruction(d1_instr),
    .AddrFault(d1_fault), .load_start(load_start), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(d1_ready),
    .load_done(d1_done), .cpu_hold(d1_hold), .words_loaded(d1_words));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the loaded program is a queue; phases are plain flags.
  logic [31:0] m_prog[$];
  bit          m_load, m_done, m_run;
  int          m_target;
  logic [31:0] m_ri;
  bit          m_rf;
  logic [31:0] p_ins, c_ins, e_ins;
  bit          p_f, c_f, e_f;

  function automatic void fetch_model(input logic [31:0] a, output logic [31:0] ins,
                                      output bit f);
    int i;
    i   = int'(a[9:2]);
    f   = (a[1:0] != 2'b00) || (a[31:10] != 22'd0) || (i >= m_prog.size());
    ins = f ? 32'h0 : m_prog[i];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prog.delete();
      m_load = 0; m_done = 0; m_run = 0; m_target = 0;
      m_ri = 32'h0; m_rf = 0;
    end else begin
      fetch_model(Address, p_ins, p_f);
      m_ri = m_run ? p_ins : 32'h0;
      m_rf = m_run && p_f;
      if (m_done) begin
        m_done = 0; m_run = 1;
      end else if (m_load) begin
        if (load_valid) begin
          m_prog.push_back(load_data);
          if (m_prog.size() == m_target) begin m_load = 0; m_done = 1; end
        end
      end else if (load_start) begin
        m_run = 0; m_load = 1; m_prog.delete();
        m_target = (load_len == 0 || load_len > 256) ? 256 : int'(load_len);
      end
    end
  end

  always @(negedge clk) begin
    fetch_model(Address, c_ins, c_f);
    e_ins = m_run ? c_ins : 32'h0;
    e_f   = m_run && c_f;
    chk("d0_instr", d0_instr, e_ins);
    chk("d0_fault", d0_fault, e_f);
    chk("d1_instr", d1_instr, m_ri);
    chk("d1_fault", d1_fault, m_rf);
    chk("d0_hold",  d0_hold,  !m_run);
    chk("d1_hold",  d1_hold,  !m_run);
    chk("d0_ready", d0_ready, m_load);
    chk("d1_ready", d1_ready, m_load);
    chk("d0_done",  d0_done,  m_done);
    chk("d1_done",  d1_done,  m_done);
    chk("d0_words", d0_words, m_prog.size());
    chk("d1_words", d1_words, m_prog.size());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bulk_load(input int len, input logic [31:0] base);
    load_start = 1; load_len = 9'(len);
    tick();
    load_start = 0;
    for (int i = 0; i < 256; i++) begin
      load_valid = 1; load_data = base + 32'(i) * 32'd7;
      tick();
    end
    load_valid = 0;
    chk("bulk_done", d0_done, 1'b1);
    tick();
    chk("bulk_words", d0_words, 9'd256);
    Address = 32'h3FC; #1;
    chk("bulk_last_c", d0_instr, base + 32'd255 * 32'd7);
    chk("bulk_last_f", d0_fault, 1'b0);
    tick();
    chk("bulk_last_r", d1_instr, base + 32'd255 * 32'd7);
  endtask

  logic [31:0] prog5 [5] = '{32'h20040005, 32'h00001026, 32'h0C000004,
                             32'h1000FFFF, 32'h23BDFFF8};
  logic [8:0]  wl_exp [5] = '{9'd1, 9'd1, 9'd2, 9'd2, 9'd3};
  logic [31:0] bad_addr [3] = '{32'h14, 32'h2, 32'h400};

  initial begin
    reset = 0; Address = 0; load_start = 0; load_len = 0;
    load_valid = 0; load_data = 0;
    tick(); tick();
    chk("rst_hold", d0_hold, 1'b1);
    chk("rst_ready", d0_ready, 1'b0);
    chk("rst_words", d0_words, 9'd0);
    chk("rst_instr_r", d1_instr, 32'h0);
    reset = 1;
    tick();

    // Five-word boot load, load_valid continuous.
    load_start = 1; load_len = 9'd5;
    tick();
    load_start = 0;
    chk("t1_ready", d0_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      load_valid = 1; load_data = prog5[i];
      tick();
    end
    load_valid = 0;
    chk("t1_done", d0_done, 1'b1);
    chk("t1_hold_done", d0_hold, 1'b1);
    tick();
    chk("t1_done_gone", d0_done, 1'b0);
    chk("t1_hold_run", d0_hold, 1'b0);
    Address = 32'h8; #1;
    chk("t1_fetch8", d0_instr, 32'h0C000004);
    chk("t1_fetch8_f", d0_fault, 1'b0);
    for (int i = 0; i < 3; i++) begin
      Address = bad_addr[i]; #1;
      chk("t2_bad_instr", d0_instr, 32'h0);
      chk("t2_bad_fault", d0_fault, 1'b1);
    end
    Address = 32'h8;
    tick();
    Address = 32'h4; #1;
    chk("t6_reg_prev", d1_instr, 32'h0C000004);
    tick();
    chk("t6_reg_new", d1_instr, 32'h00001026);

    // Reload with load_valid toggling; a stray load_start mid-load is ignored.
    load_start = 1; load_len = 9'd3;
    tick();
    load_start = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid = (i % 2 == 0);
      load_data  = 32'hA000_0000 + 32'(i);
      load_start = (i == 1);
      tick();
      chk("t3_words", d0_words, wl_exp[i]);
    end
    load_valid = 0; load_start = 0;
    chk("t3_done", d0_done, 1'b1);
    tick();
    Address = 32'h8; #1;
    chk("t3_word2", d0_instr, 32'hA000_0004);

    // Reload in RUN: coincident fetch served, hold next cycle, stale word masked.
    load_start = 1; load_len = 9'd2; #1;
    chk("t4_coinc", d0_instr, 32'hA000_0004);
    chk("t4_coinc_hold", d0_hold, 1'b0);
    tick();
    load_start = 0;
    chk("t4_hold", d0_hold, 1'b1);
    chk("t4_words0", d0_words, 9'd0);
    chk("t4_coinc_r", d1_instr, 32'hA000_0004);
    for (int i = 0; i < 2; i++) begin
      load_valid = 1; load_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    load_valid = 0;
    tick();
    #1;
    chk("t4_stale_f", d0_fault, 1'b1);
    chk("t4_stale_i", d0_instr, 32'h0);
    Address = 32'h4; #1;
    chk("t4_word1", d0_instr, 32'hB000_0001);

    // Reset during a load discards the partial program.
    load_start = 1; load_len = 9'd4;
    tick();
    load_start = 0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1; load_data = 32'hC000_0000 + 32'(i);
      tick();
    end
    reset = 0; #1;
    chk("t5_words", d0_words, 9'd0);
    chk("t5_ready", d0_ready, 1'b0);
    chk("t5_hold", d0_hold, 1'b1);
    tick();
    reset = 1;
    tick(); tick();
    chk("t5_ignored", d0_words, 9'd0);
    load_valid = 0;

    bulk_load(0, 32'h1000_0000);
    bulk_load(300, 32'h2000_0000);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
